square_wave_meas: RTL and testbench

//  Measures an incoming square wave: period (rising edge to rising edge) and

---
 rtl/sqw_pkg.sv | 19 +
 rtl/square_wave_meas_if.sv | 34 +++
 rtl/sqw_edge_detect.sv | 74 +++++++
 rtl/square_wave_meas.sv | 119 +++++++++++
 tb/tb_square_wave_meas.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqw_pkg.sv
// Shared types and constants for the square-wave measurement block.
// The optional glitch filter is selected with SQW_GLITCH_FILTER_EN.
package sqw_pkg;

    localparam int SQW_WIDTH_DEFAULT = 32;
    localparam int SQW_SYNC_MIN      = 2;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } sqw_state_t;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int sqw_cnt_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/square_wave_meas_if.sv
// Control and result signals of square_wave_meas.
// The slave modport is the measurement block; the master modport is its user.
interface square_wave_meas_if
    import sqw_pkg::*;
#(
    parameter int WIDTH = SQW_WIDTH_DEFAULT
);

    logic             enable;
    logic             sig_in;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] high_out;
    logic             meas_valid;
    logic             no_signal;

    modport master (
        output enable,
        output sig_in,
        input  period_out,
        input  high_out,
        input  meas_valid,
        input  no_signal
    );

    modport slave (
        input  enable,
        input  sig_in,
        output period_out,
        output high_out,
        output meas_valid,
        output no_signal
    );

endinterface

// File: rtl/sqw_edge_detect.sv
// Synchronizer, optional glitch filter (SQW_GLITCH_FILTER_EN) and edge detector
// for an asynchronous level input.
module sqw_edge_detect
    import sqw_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < SQW_SYNC_MIN || GLITCH_CYCLES < 1) begin : g_param_check
        $error("sqw_edge_detect: SYNC_STAGES must be >= 2 and GLITCH_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;
    logic                   cur;
    logic                   prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

`ifdef SQW_GLITCH_FILTER_EN
    localparam int GW = sqw_cnt_bits(GLITCH_CYCLES);
    localparam logic [GW-1:0] HOLD_TC = GW'(GLITCH_CYCLES - 1);

    logic [GW-1:0] hold_cnt;
    logic          filt_q;

    // Down-counter reloads whenever the input agrees with the filtered level,
    // so the level only moves after GLITCH_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q   <= 1'b0;
            hold_cnt <= HOLD_TC;
        end else if (sync_level == filt_q) begin
            hold_cnt <= HOLD_TC;
        end else if (hold_cnt == '0) begin
            filt_q   <= sync_level;
            hold_cnt <= HOLD_TC;
        end else begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign cur = filt_q;
`else
    assign cur = sync_level;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;
    assign fall = ~cur & prev;

endmodule

// File: rtl/square_wave_meas.sv
// Square-wave period / high-time meter with loss-of-signal timeout.
// Build option SQW_GLITCH_FILTER_EN enables the input glitch filter.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_HUNT | waiting for a rise to start a measurement (falls ignored)
//  ST_HIGH | input high, waiting for the fall that latches the high time
//  ST_LOW  | input low, waiting for the rise that publishes the result
module square_wave_meas
    import sqw_pkg::*;
#(
    parameter int WIDTH          = SQW_WIDTH_DEFAULT,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int GLITCH_CYCLES  = 4
) (
    input logic                clk,
    input logic                reset,
    square_wave_meas_if.slave  bus
);

    localparam int               IW         = sqw_cnt_bits(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [IW-1:0]    IDLE_MAX   = '1;
    localparam logic [IW-1:0]    TIMEOUT_TC = IW'(TIMEOUT_CYCLES - 1);

    logic             rise;
    logic             fall;
    logic             timeout;
    sqw_state_t       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hi_lat;
    logic [IW-1:0]    idle_cnt;

    sqw_edge_detect #(
        .SYNC_STAGES   (SYNC_STAGES),
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) u_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (bus.sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    // An edge in the same cycle always beats the timeout.
    assign timeout = bus.enable && !rise && !fall && (idle_cnt == TIMEOUT_TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= WIDTH'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Idle time is measured only while enabled, so a re-enable restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!bus.enable || rise || fall) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_HUNT;
            hi_lat         <= '0;
            bus.period_out <= '0;
            bus.high_out   <= '0;
            bus.meas_valid <= 1'b0;
            bus.no_signal  <= 1'b0;
        end else begin
            bus.meas_valid <= 1'b0;
            if (!bus.enable) begin
                state <= ST_HUNT;
            end else if (timeout) begin
                state          <= ST_HUNT;
                bus.no_signal  <= 1'b1;
                bus.period_out <= '0;
                bus.high_out   <= '0;
            end else begin
                case (state)
                    ST_HUNT: begin
                        if (rise) begin
                            state <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            hi_lat <= cnt;
                            state  <= ST_LOW;
                        end else if (rise) begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            bus.period_out <= cnt;
                            bus.high_out   <= hi_lat;
                            bus.meas_valid <= 1'b1;
                            bus.no_signal  <= 1'b0;
                            state          <= ST_HIGH;
                        end else if (fall) begin
                            state <= ST_HUNT;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_square_wave_meas.sv
// Randomized self-checking bench for square_wave_meas against a segment-level
// reference model of the driven waveform (honours SQW_GLITCH_FILTER_EN).
module tb_square_wave_meas;

    localparam int W       = 16;
    localparam int SAT_W   = 6;
    localparam int TIMEOUT = 100;
    localparam longint MAIN_MAX = (64'd1 << W) - 1;
    localparam longint SAT_MAX  = (64'd1 << SAT_W) - 1;
`ifdef SQW_GLITCH_FILTER_EN
    localparam int T_SHORT  = 4;
    localparam int FILT_LAT = 4;
`else
    localparam int T_SHORT  = 3;
    localparam int FILT_LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    square_wave_meas_if #(.WIDTH(W))     bus ();
    square_wave_meas_if #(.WIDTH(SAT_W)) sat_bus ();

    square_wave_meas #(
        .WIDTH(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT), .GLITCH_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    square_wave_meas #(
        .WIDTH(SAT_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1000), .GLITCH_CYCLES(4)
    ) dut_sat (
        .clk(clk), .reset(reset), .bus(sat_bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: timestamps of level changes, in clock cycles.
    int unsigned cyc = 0;
    int unsigned t_edge = 0, t_rise = 0, t_fall = 0;
    bit          have_rise = 0, have_fall = 0, cur_level = 0;
    longint      exp_p[$];
    longint      exp_h[$];
    longint      last_p = 0, last_h = 0;
    bit          exp_nosig = 0;
    int          n_valid = 0;
    bit          sat_armed = 0, sat_seen = 0;

    function automatic longint clamp(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_level(input bit lvl);
        longint p, h;
        if (lvl != cur_level) begin
            if (cyc - t_edge >= TIMEOUT) begin
                have_rise = 0;
                last_p = 0;
                last_h = 0;
                exp_nosig = 1;
            end
            if (lvl) begin
                if (have_rise && have_fall) begin
                    p = clamp(longint'(cyc - t_rise), MAIN_MAX);
                    h = clamp(longint'(t_fall - t_rise), MAIN_MAX);
                    exp_p.push_back(p);
                    exp_h.push_back(h);
                    last_p = p;
                    last_h = h;
                    exp_nosig = 0;
                end
                have_rise = 1;
                have_fall = 0;
                t_rise = cyc;
            end else if (have_rise) begin
                have_fall = 1;
                t_fall = cyc;
            end
            cur_level = lvl;
            t_edge = cyc;
        end
    endtask

    task automatic raw(input bit lvl, input int n);
        bus.sig_in = lvl;
        sat_bus.sig_in = lvl;
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic drive(input bit lvl, input int n);
        model_level(lvl);
        raw(lvl, n);
    endtask

    task automatic set_enable(input bit v);
        bus.enable = v;
        if (!v) have_rise = 0;
        else    t_edge = cyc;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_pending"}, exp_p.size(), 0);
        check_eq({tag, "_period"}, bus.period_out, last_p);
        check_eq({tag, "_high"}, bus.high_out, last_h);
        check_eq({tag, "_nosig"}, bus.no_signal, exp_nosig);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.meas_valid) begin
            n_valid++;
            check_eq("valid_expected", exp_p.size() > 0, 1);
            if (exp_p.size() > 0) begin
                check_eq("period", bus.period_out, exp_p.pop_front());
                check_eq("high", bus.high_out, exp_h.pop_front());
                check_eq("nosig_at_valid", bus.no_signal, 0);
            end
        end
        if (!reset && sat_armed && sat_bus.meas_valid) begin
            sat_seen = 1;
            check_eq("sat_period", sat_bus.period_out, clamp(75, SAT_MAX));
            check_eq("sat_high", sat_bus.high_out, clamp(70, SAT_MAX));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int v0;
        int hi, lo;
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.sig_in = 1'b0;
        sat_bus.enable = 1'b1;
        sat_bus.sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_period", bus.period_out, 0);
        check_eq("rst_high", bus.high_out, 0);
        check_eq("rst_valid", bus.meas_valid, 0);
        check_eq("rst_nosig", bus.no_signal, 0);
        reset = 1'b0;
        t_edge = cyc;

        // 1: steady short-high wave
        v0 = n_valid;
        repeat (6) begin
            drive(1, T_SHORT);
            drive(0, 10 - T_SHORT);
        end
        drive(0, 10);
        check_eq("t1_valid_count", n_valid - v0, 5);
        check_quiet("t1");

        // 2: duty change mid-stream
        repeat (2) begin drive(1, T_SHORT); drive(0, 10 - T_SHORT); end
        repeat (3) begin drive(1, 6); drive(0, 4); end
        drive(1, 6);
        drive(0, 12);
        check_quiet("t2");

        // random waves with occasional enable drops in the low phase
        repeat (40) begin
            hi = $urandom_range(4, 30);
            lo = $urandom_range(4, 30);
            drive(1, hi);
            if (lo >= 14 && $urandom_range(0, 2) == 0) begin
                drive(0, 6);
                set_enable(0);
                check_eq("en_hold_period", bus.period_out, last_p);
                check_eq("en_hold_high", bus.high_out, last_h);
                drive(0, 3);
                set_enable(1);
                drive(0, lo - 9);
            end else begin
                drive(0, lo);
            end
        end
        drive(0, 20);
        check_quiet("rand");

        // 3: stuck high -> timeout, then recovery
        drive(1, 101 + FILT_LAT);
        check_eq("t3_nosig_early", bus.no_signal, 0);
        drive(1, 3);
        check_eq("t3_nosig", bus.no_signal, 1);
        check_eq("t3_period_zero", bus.period_out, 0);
        check_eq("t3_high_zero", bus.high_out, 0);
        drive(0, 5);
        drive(1, T_SHORT);
        drive(0, 10 - T_SHORT);
        check_eq("t3_nosig_held", bus.no_signal, 1);
        drive(1, T_SHORT);
        drive(0, 12);
        check_quiet("t3");

        // 4: enable dropped during low, restored, needs a full cycle again
        drive(1, 5);
        drive(0, 6);
        set_enable(0);
        drive(0, 4);
        set_enable(1);
        v0 = n_valid;
        drive(0, 4);
        drive(1, 5);
        drive(0, 8);
        check_eq("t4_no_valid", n_valid - v0, 0);
        check_eq("t4_hold_period", bus.period_out, last_p);
        drive(1, 5);
        drive(0, 12);
        check_eq("t4_valid", n_valid - v0, 1);
        check_quiet("t4");

        // 5: reset mid-high, then a saturating wave on the narrow instance
        drive(1, 8);
        reset = 1'b1;
        bus.sig_in = 1'b0;
        sat_bus.sig_in = 1'b0;
        #1;
        check_eq("t5_period", bus.period_out, 0);
        check_eq("t5_high", bus.high_out, 0);
        check_eq("t5_valid", bus.meas_valid, 0);
        check_eq("t5_nosig", bus.no_signal, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        have_rise = 0;
        cur_level = 0;
        last_p = 0;
        last_h = 0;
        exp_nosig = 0;
        t_edge = cyc;
        sat_armed = 1;
        drive(0, 5);
        drive(1, 70);
        drive(0, 5);
        drive(1, 6);
        drive(0, 10);
        sat_armed = 0;
        check_eq("t5_sat_seen", sat_seen, 1);
        check_quiet("t5");

        // 6: short low glitch inside a 6-cycle high
        drive(0, 7);
`ifdef SQW_GLITCH_FILTER_EN
        model_level(1); raw(1, 2); raw(0, 2); raw(1, 2);
        model_level(0); raw(0, 4);
`else
        drive(1, 2); drive(0, 2); drive(1, 2); drive(0, 4);
`endif
        drive(1, 4);
        drive(0, 6);
        drive(1, 4);
        drive(0, 14);
        check_quiet("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
